// File: rtl/mem_port_arbiter.sv
// Three-port round-robin arbiter in front of a single shared memory port.
// A transaction is granted from IDLE, runs in BUSY until the memory acks
// (or the wait counter expires), then spends one TURN cycle with the bus idle.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_access,
    input  logic [19:1] m0_addr,
    input  logic [15:0] m0_data_out,
    input  logic        m0_wr_en,
    input  logic [1:0]  m0_bytesel,
    output logic [15:0] m0_data_in,
    output logic        m0_ack,

    input  logic        m1_access,
    input  logic [19:1] m1_addr,
    input  logic [15:0] m1_data_out,
    input  logic        m1_wr_en,
    input  logic [1:0]  m1_bytesel,
    output logic [15:0] m1_data_in,
    output logic        m1_ack,

    input  logic        m2_access,
    input  logic [19:1] m2_addr,
    input  logic [15:0] m2_data_out,
    input  logic        m2_wr_en,
    input  logic [1:0]  m2_bytesel,
    output logic [15:0] m2_data_in,
    output logic        m2_ack,

    output logic        q_m_access,
    output logic [19:1] q_m_addr,
    output logic [15:0] q_m_data_out,
    output logic        q_m_wr_en,
    output logic [1:0]  q_m_bytesel,
    input  logic        q_m_ack,
    input  logic [15:0] q_m_data_in,

    input  logic        clear_err,
    output logic        timeout_err,
    output logic [1:0]  timeout_port
);

    localparam int unsigned DATA_W   = 16;
    // Wait count value at which the current BUSY cycle is the last one allowed.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

    // Per-port views of the request buses so the mux can be written as a loop.
    logic [2:0]        req;
    logic [19:1]       addr_a  [3];
    logic [DATA_W-1:0] wdata_a [3];
    logic [2:0]        wr_a;
    logic [1:0]        bsel_a  [3];
    logic [2:0]        ack_v;
    logic [DATA_W-1:0] rdata_a [3];

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [1:0]  tport_q, tport_d;

    logic [1:0]  win;
    logic        tmo_hit;

    assign req        = {m2_access, m1_access, m0_access};
    assign addr_a[0]  = m0_addr;
    assign addr_a[1]  = m1_addr;
    assign addr_a[2]  = m2_addr;
    assign wdata_a[0] = m0_data_out;
    assign wdata_a[1] = m1_data_out;
    assign wdata_a[2] = m2_data_out;
    assign wr_a       = {m2_wr_en, m1_wr_en, m0_wr_en};
    assign bsel_a[0]  = m0_bytesel;
    assign bsel_a[1]  = m1_bytesel;
    assign bsel_a[2]  = m2_bytesel;

    // Search starts at the port after the last one granted, wrapping modulo 3.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cand = 2'((int'(last) + i) % 3);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign win     = rr_pick(rr_ptr_q, req);
    // A real ack in the final allowed cycle takes precedence over the timeout.
    assign tmo_hit = (state_q == BUSY) && !q_m_ack && (cnt_q == TMO_LAST);

    // State and bookkeeping registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= 2'd2;
            rr_ptr_q <= 2'd2;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            tport_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            tport_q  <= tport_d;
        end
    end

    // Next-state logic: grant from IDLE, finish BUSY on ack or timeout, TURN for one cycle.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        tport_d  = tport_q;
        if (clear_err) begin
            err_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = BUSY;
                    grant_d  = win;
                    rr_ptr_d = win;
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                if (q_m_ack) begin
                    state_d = TURN;
                end else if (tmo_hit) begin
                    state_d = TURN;
                    err_d   = 1'b1;
                    tport_d = grant_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: in BUSY the granted port drives the shared bus and alone sees the response.
    always_comb begin
        q_m_access   = 1'b0;
        q_m_addr     = '0;
        q_m_data_out = '0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = '0;
        ack_v        = '0;
        for (int i = 0; i < 3; i++) begin
            rdata_a[i] = '0;
        end
        if (state_q == BUSY) begin
            q_m_access = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (grant_q == 2'(i)) begin
                    q_m_addr     = addr_a[i];
                    q_m_data_out = wdata_a[i];
                    q_m_wr_en    = wr_a[i];
                    q_m_bytesel  = bsel_a[i];
                    if (q_m_ack) begin
                        ack_v[i]   = 1'b1;
                        rdata_a[i] = q_m_data_in;
                    end else if (tmo_hit) begin
                        ack_v[i]   = 1'b1;
                        rdata_a[i] = 16'hFFFF;
                    end
                end
            end
        end
    end

    assign m0_ack       = ack_v[0];
    assign m1_ack       = ack_v[1];
    assign m2_ack       = ack_v[2];
    assign m0_data_in   = rdata_a[0];
    assign m1_data_in   = rdata_a[1];
    assign m2_data_in   = rdata_a[2];
    assign timeout_err  = err_q;
    assign timeout_port = tport_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: three requester drivers, a
// memory responder with random latency (including no response), and a monitor
// that checks every cycle against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [2:0]  acc_v;
    logic [18:0] addr_v [3];
    logic [15:0] wdat_v [3];
    logic [2:0]  wr_v;
    logic [1:0]  bsel_v [3];
    logic        q_m_ack_r;
    logic [15:0] q_m_din_r;
    logic        clear_err;

    logic [15:0] m0_din, m1_din, m2_din;
    logic        m0_ack, m1_ack, m2_ack;
    logic        q_m_access;
    logic [18:0] q_m_addr;
    logic [15:0] q_m_data_out;
    logic        q_m_wr_en;
    logic [1:0]  q_m_bytesel;
    logic        timeout_err;
    logic [1:0]  timeout_port;
    logic [2:0]  ack_v;

    assign ack_v = {m2_ack, m1_ack, m0_ack};

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_access(acc_v[0]), .m0_addr(addr_v[0]), .m0_data_out(wdat_v[0]),
        .m0_wr_en(wr_v[0]), .m0_bytesel(bsel_v[0]), .m0_data_in(m0_din), .m0_ack(m0_ack),
        .m1_access(acc_v[1]), .m1_addr(addr_v[1]), .m1_data_out(wdat_v[1]),
        .m1_wr_en(wr_v[1]), .m1_bytesel(bsel_v[1]), .m1_data_in(m1_din), .m1_ack(m1_ack),
        .m2_access(acc_v[2]), .m2_addr(addr_v[2]), .m2_data_out(wdat_v[2]),
        .m2_wr_en(wr_v[2]), .m2_bytesel(bsel_v[2]), .m2_data_in(m2_din), .m2_ack(m2_ack),
        .q_m_access(q_m_access), .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out),
        .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
        .q_m_ack(q_m_ack_r), .q_m_data_in(q_m_din_r),
        .clear_err(clear_err), .timeout_err(timeout_err), .timeout_port(timeout_port)
    );

    typedef struct {
        int          port;
        logic [15:0] data;
        int          bcyc;
        bit          tmo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          pending [3];
    int          req_cyc [3];
    int          last_g = 2;
    int          cur_port = 0;
    bit          run = 1'b0;
    bit          mem_en = 1'b0;
    bit          mon_en = 1'b0;
    int          mon_busy = 0;
    bit          turn_exp = 1'b0;
    bit          m_err = 1'b0;
    int          m_port = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] din_of(input int p);
        case (p)
            0:       return m0_din;
            1:       return m1_din;
            default: return m2_din;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Requester: random gap, random request, hold until its ack, then drop.
    task automatic drive_port(input int p);
        int n;
        while (run) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            @(posedge clk);
            #1;
            if (!run) break;
            addr_v[p] = 19'($urandom);
            wdat_v[p] = 16'($urandom);
            wr_v[p]   = 1'($urandom);
            bsel_v[p] = 2'($urandom);
            acc_v[p]  = 1'b1;
            pending[p] = 1'b1;
            req_cyc[p] = cyc;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ack_v[p] && n < 60);
            chk($sformatf("ack_wait_port%0d", p), 64'(ack_v[p]), 64'd1);
            @(posedge clk);
            #1;
            acc_v[p]   = 1'b0;
            pending[p] = 1'b0;
        end
    endtask

    // Memory responder: predicts the grantee from the round-robin rule and
    // queues the response the grantee should receive.
    initial begin
        int          busy_n;
        int          lat;
        int          w;
        int          r;
        int          c;
        logic [15:0] d;
        exp_t        e;
        busy_n = 0;
        lat    = 0;
        d      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                if (q_m_access) begin
                    busy_n++;
                    if (busy_n == 1) begin
                        w = -1;
                        for (int i = 1; i <= 3; i++) begin
                            c = (last_g + i) % 3;
                            if (w < 0 && pending[c] && req_cyc[c] < cyc) w = c;
                        end
                        chk("grant_has_eligible_req", 64'(w >= 0), 64'd1);
                        if (w < 0) w = 0;
                        last_g   = w;
                        cur_port = w;
                        r = $urandom_range(0, 9);
                        if (r < 6)      lat = 1 + $urandom_range(0, 3);
                        else if (r < 8) lat = TMO;
                        else            lat = TMO + 5;
                        d = 16'($urandom);
                        e.port = w;
                        if (lat <= TMO) begin
                            e.data = d;
                            e.bcyc = lat;
                            e.tmo  = 1'b0;
                        end else begin
                            e.data = 16'hFFFF;
                            e.bcyc = TMO;
                            e.tmo  = 1'b1;
                        end
                        sb_q.push_back(e);
                    end
                    q_m_ack_r = (busy_n == lat);
                    q_m_din_r = (busy_n == lat) ? d : 16'($urandom);
                end else begin
                    busy_n    = 0;
                    q_m_ack_r = ($urandom_range(0, 3) == 0);
                    q_m_din_r = 16'($urandom);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            clear_err = run && ($urandom_range(0, 5) == 0);
        end
    end

    // Monitor: bus mirroring, response routing, TURN gap and sticky error flag.
    always @(negedge clk) begin
        exp_t e;
        bit   tmo_now;
        if (mon_en) begin
            if (q_m_access) begin
                mon_busy++;
                chk("q_m_addr", 64'(q_m_addr), 64'(addr_v[cur_port]));
                chk("q_m_wfields", 64'({q_m_data_out, q_m_wr_en, q_m_bytesel}),
                    64'({wdat_v[cur_port], wr_v[cur_port], bsel_v[cur_port]}));
            end else begin
                mon_busy = 0;
                chk("q_m_idle_zero", 64'({q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel}), 64'd0);
            end
            if (turn_exp) chk("turn_gap", 64'(q_m_access), 64'd0);
            turn_exp = 1'b0;
            tmo_now  = 1'b0;
            e.port   = 0;
            if (ack_v != 3'b000) begin
                chk("ack_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("ack_port", 64'(ack_v), 64'(3'b001 << e.port));
                    chk("ack_data", 64'(din_of(e.port)), 64'(e.data));
                    chk("ack_busy_cycle", 64'(mon_busy), 64'(e.bcyc));
                    tmo_now = e.tmo;
                end
                turn_exp = 1'b1;
            end
            for (int p = 0; p < 3; p++) begin
                if (!ack_v[p]) chk($sformatf("data_in_zero_port%0d", p), 64'(din_of(p)), 64'd0);
            end
            chk("timeout_err", 64'(timeout_err), 64'(m_err));
            chk("timeout_port", 64'(timeout_port), 64'(m_port));
            if (tmo_now) begin
                m_err  = 1'b1;
                m_port = e.port;
            end else if (clear_err) begin
                m_err = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        acc_v     = 3'b111;
        wr_v      = 3'b111;
        for (int p = 0; p < 3; p++) begin
            addr_v[p]  = 19'h7FFFF;
            wdat_v[p]  = 16'hFFFF;
            bsel_v[p]  = 2'b11;
            pending[p] = 1'b0;
            req_cyc[p] = 0;
        end
        q_m_ack_r = 1'b1;
        q_m_din_r = 16'hABCD;
        clear_err = 1'b0;

        // Reset state with every input active.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_m_access", 64'(q_m_access), 64'd0);
        chk("rst_q_m_fields", 64'({q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel}), 64'd0);
        chk("rst_acks", 64'(ack_v), 64'd0);
        chk("rst_data_in", 64'({m0_din, m1_din, m2_din}), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_timeout_port", 64'(timeout_port), 64'd0);
        acc_v     = 3'b000;
        q_m_ack_r = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised traffic.
        mem_en = 1'b1;
        mon_en = 1'b1;
        run    = 1'b1;
        for (int p = 0; p < 3; p++) begin
            fork
                automatic int pp = p;
                drive_port(pp);
            join_none
        end
        repeat (3000) @(posedge clk);
        run = 1'b0;
        repeat (120) @(posedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        chk("requests_released", 64'(acc_v), 64'd0);

        // Reset in the middle of a transaction.
        @(posedge clk);
        #1;
        mon_en    = 1'b0;
        mem_en    = 1'b0;
        q_m_ack_r = 1'b0;
        addr_v[2] = 19'h2A5A5;
        acc_v[2]  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!q_m_access && n < 10);
        chk("midrst_busy_reached", 64'(q_m_access), 64'd1);
        chk("midrst_busy_addr", 64'(q_m_addr), 64'h2A5A5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_access_drop", 64'(q_m_access), 64'd0);
        chk("midrst_no_ack", 64'(ack_v), 64'd0);
        chk("midrst_err_clear", 64'(timeout_err), 64'd0);
        addr_v[0] = 19'h01234;
        acc_v[0]  = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!q_m_access && n < 10);
        chk("postrst_access", 64'(q_m_access), 64'd1);
        chk("postrst_grant_m0", 64'(q_m_addr), 64'h01234);
        chk("postrst_no_ack", 64'(ack_v), 64'd0);
        @(posedge clk);
        #1;
        q_m_ack_r = 1'b1;
        q_m_din_r = 16'h1234;
        @(negedge clk);
        chk("postrst_m0_ack", 64'(ack_v), 64'b001);
        chk("postrst_m0_data", 64'(m0_din), 64'h1234);
        @(posedge clk);
        #1;
        q_m_ack_r = 1'b0;
        acc_v[0]  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!q_m_access && n < 10);
        chk("postrst_next_grant_m2", 64'(q_m_addr), 64'h2A5A5);
        @(posedge clk);
        #1;
        q_m_ack_r = 1'b1;
        q_m_din_r = 16'h5678;
        @(negedge clk);
        chk("postrst_m2_ack", 64'(ack_v), 64'b100);
        chk("postrst_m2_data", 64'(m2_din), 64'h5678);
        @(posedge clk);
        #1;
        q_m_ack_r = 1'b0;
        acc_v[2]  = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: MemPortArbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles allowed for a q_m_ack before the arbiter forces completion (range 2..65535).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 mN_access  input  1  request from port N, N in {0,1,2}; held high until mN_ack.
REQ-005 mN_addr  input  19  word address [19:1] for port N.
REQ-006 mN_data_out  input  16  write data from port N.
REQ-007 mN_wr_en  input  1  write strobe for port N.
REQ-008 mN_bytesel  input  2  byte lanes for port N.
REQ-009 mN_data_in  output  16  read data to port N.
REQ-010 mN_ack  output  1  one-cycle completion pulse to port N.
REQ-011 q_m_access, q_m_addr[19:1], q_m_data_out[16], q_m_wr_en, q_m_bytesel[2]  output  shared memory port request.
REQ-012 q_m_ack  input  1 and q_m_data_in  input  16: shared port completion and read data.
REQ-013 clear_err  input  1  synchronous clear of the sticky timeout flag.
REQ-014 timeout_err  output  1 and timeout_port  output  2: sticky timeout flag and the port that timed out.

Function
REQ-015 States: IDLE, BUSY, TURN; exactly one port granted in BUSY, none granted in IDLE or TURN.
REQ-016 IDLE: any mN_access high at a rising edge -> BUSY next cycle with the grant registered; q_m_access rises in the first BUSY cycle (one-cycle request-to-bus latency).
REQ-017 Round-robin arbitration: search begins at the port after the last granted one; pointer resets to 2, so port 0 wins first.
REQ-018 In BUSY, q_m_access=1 and q_m_addr/data_out/wr_en/bytesel mirror the granted port's inputs combinationally; in IDLE and TURN, all q_m_* outputs are 0.
REQ-019 In BUSY with q_m_ack=1: grantee mN_ack=1 and mN_data_in=q_m_data_in in the same cycle; next state is TURN.
REQ-020 Non-granted ports see mN_ack=0 and mN_data_in=0 at all times.
REQ-021 TURN lasts exactly one cycle with q_m_access=0, then returns to IDLE; back-to-back requests therefore complete at most once every 3 cycles plus memory latency.
REQ-022 A 16-bit wait counter clears on BUSY entry and increments each BUSY cycle without q_m_ack.
REQ-023 When the counter reaches TIMEOUT-1 without q_m_ack: grantee ack=1 with data 16'hFFFF; timeout_err<=1; timeout_port<=grant index; next state TURN.
REQ-024 q_m_ack and the timeout in the same cycle: normal completion wins (real data, no error).
REQ-025 If the grantee drops mN_access while in BUSY (a protocol violation), the transaction completes normally; the arbiter does not abort it.
REQ-026 q_m_ack in IDLE or TURN is ignored.
REQ-027 clear_err=1 clears timeout_err; a timeout in the same cycle wins, leaving timeout_err=1.

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, RR pointer=2, counter=0, timeout_err=0, timeout_port=0; all mN_ack, mN_data_in and q_m_* outputs=0.
REQ-029 Reset asserted mid-BUSY abandons the transaction with no ack; after release the arbiter starts from IDLE.

Verification
REQ-030 Single read: m1 reads addr 0x12345, q_m_ack with data 0xBEEF three cycles later -> q_m_addr=0x12345 from cycle 1; m1_ack pulses once with 0xBEEF; TURN cycle has q_m_access=0.
REQ-031 All three ports request together from reset, memory acks after 1 cycle -> grants in order 0,1,2,0; each completion is 3 cycles apart.
REQ-032 Write: m2 with wr_en=1, bytesel=2'b10, data 0xA55A -> q_m outputs match exactly; m2_ack is one cycle; other acks stay 0.
REQ-033 TIMEOUT=8, memory never acks m0 -> m0_ack with 0xFFFF in BUSY cycle 8, timeout_err=1, timeout_port=0; then clear_err -> 0.
REQ-034 q_m_ack arrives in the same cycle the timeout fires -> real data returned and timeout_err stays 0.
REQ-035 reset_n low during BUSY -> q_m_access drops immediately with no ack; after release, m0 is granted first.
